alu_grf: RTL and testbench
==========================

ALU_GRF -- requirements
Module: alu_grf

Interface
REQ-001 Parameters: none; widths are fixed.
REQ-002 Clock/reset: one clock; reset is asynchronous and active-high.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  asynchronous active-high reset.
REQ-005 i_clk_en  input  1  register-file write qualifier.
REQ-006 i_cs_b  input  1  active-low write select.
REQ-007 i_waddr  input  4  write register index.
REQ-008 i_wen  input  4  per-byte write enables; bit n enables din[8n+7:8n].
REQ-009 i_din  input  32  write data.
REQ-010 i_raddr_0, i_raddr_1  input  4 each  read port indices.
REQ-011 o_dout_0, o_dout_1  output  32 each  read port data.
REQ-012 i_alu_a, i_alu_b  input  32 each  ALU operands A and B.
REQ-013 i_cin, i_vin  input  1 each  incoming carry and overflow flags.
REQ-014 i_opcode  input  6  ALU operation.
REQ-015 o_alu_dout  output  32  ALU result.
REQ-016 o_cout, o_vout  output  1 each  outgoing carry and overflow flags.
REQ-017 o_mcp  output  1  multicycle-path request.

Function
REQ-018 Register file: 16 x 32-bit registers, one write port, two read ports.
REQ-019 Write condition: rising i_clk with i_clk_en=1 and i_cs_b=0.
- Writes only bytes whose i_wen bit is set; other bytes hold.
- i_wen=0000 changes nothing.
REQ-020 Reads: combinational, any index, both ports independent.
- Read of the register being written returns the old value until the edge (no write-through).
REQ-021 ALU is purely combinational: outputs settle in the same cycle, no latency.
REQ-022 Defaults for any op not listed below: o_cout=i_cin, o_vout=i_vin.
REQ-023 Opcode map (hex), results mod 2^32:
- 00 MOV: B.
- 02 LMOVT: B<<16.
- 04 AND: A&B.
- 06 OR: A|B.
- 08 XOR: A^B.
- 0A ADD: A+B.
- 0C ADC: A+B+cin.
- 0E SUB: A+~B+1.
- 10 SBC: A+~B+cin.
- 12 MUL: low 32 bits of A*B.
- 14 ASR: A>>>B[4:0].
- 16 LSR: A>>B[4:0].
- 18 ASL: A<<B[4:0].
- 1A ROR: A rotated right by B[4:0].
- All other opcodes: B.
REQ-024 Flags for ADD/ADC/SUB/SBC:
- o_cout = carry out of bit 31 of the 33-bit sum; for subtract, 1 means no borrow.
- o_vout = signed overflow (operand signs equal, result sign differs).
REQ-025 Flags for shifts/rotate:
- o_cout = last bit shifted out.
- Shift amount 0: o_cout=i_cin and result = A.
- o_vout=i_vin.
REQ-026 o_mcp=1 exactly when i_opcode=12 (MUL), else 0.

Reset
REQ-027 While i_rst=1, all 16 registers are cleared to 0 immediately and writes are ignored.
REQ-028 Reset has no effect on ALU outputs, which remain a pure function of inputs.

Verification
REQ-029 Reset mid-run: after registers are loaded, assert i_rst between edges -> o_dout_0/1 read 0 for every index without waiting for a clock edge.
REQ-030 Byte write: R3=0x11223344, then write i_din=0xAABBCCDD with i_wen=0100 -> R3=0x11BB3344; write with i_wen=1111 but i_clk_en=0 -> R3 unchanged.
REQ-031 Same-cycle read: i_raddr_0=i_waddr=5 during a write -> old value before the edge, new value after.
REQ-032 Arithmetic:
- ADD 0xFFFFFFFF+1 -> 0, cout=1, vout=0.
- ADD 0x7FFFFFFF+1 -> 0x80000000, vout=1.
- SUB 5-7 -> 0xFFFFFFFE, cout=0.
- SUB 7-5 -> 2, cout=1.
REQ-033 Shifts:
- ASR 0x80000000 by 4 -> 0xF8000000.
- LSR 0x00000003 by 1 -> 1, cout=1.
- ROR 0x00000001 by 1 -> 0x80000000.
- Shift by 0 -> A, cout=i_cin.
REQ-034 MUL/LMOVT:
- MUL 0x00010000*0x00010001 -> 0x00010000, o_mcp=1.
- LMOVT B=0x1234 -> 0x12340000, o_mcp=0.

Source files
------------

// File: rtl/alu_grf.sv
// rtl/alu_grf.sv - 16x32 byte-writable register file with a combinational ALU
// Register file clears asynchronously; the ALU is a pure function of its inputs.
module alu_grf (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic        i_cs_b,
  input  logic [3:0]  i_waddr,
  input  logic [3:0]  i_wen,
  input  logic [31:0] i_din,
  input  logic [3:0]  i_raddr_0,
  input  logic [3:0]  i_raddr_1,
  output logic [31:0] o_dout_0,
  output logic [31:0] o_dout_1,
  input  logic [31:0] i_alu_a,
  input  logic [31:0] i_alu_b,
  input  logic        i_cin,
  input  logic        i_vin,
  input  logic [5:0]  i_opcode,
  output logic [31:0] o_alu_dout,
  output logic        o_cout,
  output logic        o_vout,
  output logic        o_mcp
);

  logic [31:0] regs_q [16];
  logic        wr_en_d;

  assign wr_en_d = i_clk_en && !i_cs_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (wr_en_d) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wen[b]) regs_q[i_waddr][b*8 +: 8] <= i_din[b*8 +: 8];
      end
    end
  end

  // Reads see the stored value only; a same-cycle write lands at the edge.
  assign o_dout_0 = regs_q[i_raddr_0];
  assign o_dout_1 = regs_q[i_raddr_1];

  logic [31:0] add_b_d;
  logic        add_cin_d;
  logic [32:0] sum_d;
  logic        ovf_d;
  logic [4:0]  shamt_d;
  logic [4:0]  shamt_m1_d;
  logic [4:0]  asl_idx_d;
  logic [31:0] mul_d;
  logic [31:0] asr_d;
  logic [31:0] lsr_d;
  logic [31:0] asl_d;
  logic [31:0] ror_d;
  logic [31:0] alu_d;
  logic        cout_d;
  logic        vout_d;

  // Subtract variants reuse the adder with the inverted B operand.
  always_comb begin
    add_b_d   = i_alu_b;
    add_cin_d = 1'b0;
    case (i_opcode)
      6'h0C: add_cin_d = i_cin;
      6'h0E: begin add_b_d = ~i_alu_b; add_cin_d = 1'b1;  end
      6'h10: begin add_b_d = ~i_alu_b; add_cin_d = i_cin; end
      default: ;
    endcase
  end

  assign sum_d      = {1'b0, i_alu_a} + {1'b0, add_b_d} + {32'b0, add_cin_d};
  assign ovf_d      = (i_alu_a[31] == add_b_d[31]) && (sum_d[31] != i_alu_a[31]);
  assign shamt_d    = i_alu_b[4:0];
  assign shamt_m1_d = shamt_d - 5'd1;
  assign asl_idx_d  = 5'(6'd32 - {1'b0, shamt_d});
  assign mul_d      = i_alu_a * i_alu_b;
  assign asr_d      = $unsigned($signed(i_alu_a) >>> shamt_d);
  assign lsr_d      = i_alu_a >> shamt_d;
  assign asl_d      = i_alu_a << shamt_d;
  assign ror_d      = (i_alu_a >> shamt_d) | (i_alu_a << (6'd32 - {1'b0, shamt_d}));

  always_comb begin
    alu_d  = i_alu_b;
    cout_d = i_cin;
    vout_d = i_vin;
    case (i_opcode)
      6'h02: alu_d = {i_alu_b[15:0], 16'h0000};
      6'h04: alu_d = i_alu_a & i_alu_b;
      6'h06: alu_d = i_alu_a | i_alu_b;
      6'h08: alu_d = i_alu_a ^ i_alu_b;
      6'h0A, 6'h0C, 6'h0E, 6'h10: begin
        alu_d  = sum_d[31:0];
        cout_d = sum_d[32];
        vout_d = ovf_d;
      end
      6'h12: alu_d = mul_d;
      6'h14: begin
        alu_d = asr_d;
        if (shamt_d != 5'd0) cout_d = i_alu_a[shamt_m1_d];
      end
      6'h16: begin
        alu_d = lsr_d;
        if (shamt_d != 5'd0) cout_d = i_alu_a[shamt_m1_d];
      end
      6'h18: begin
        alu_d = asl_d;
        if (shamt_d != 5'd0) cout_d = i_alu_a[asl_idx_d];
      end
      6'h1A: begin
        alu_d = ror_d;
        if (shamt_d != 5'd0) cout_d = i_alu_a[shamt_m1_d];
      end
      default: ;
    endcase
  end

  assign o_alu_dout = alu_d;
  assign o_cout     = cout_d;
  assign o_vout     = vout_d;
  assign o_mcp      = (i_opcode == 6'h12);

endmodule

// File: tb/tb_alu_grf.sv
// tb/tb_alu_grf.sv - scoreboard bench for alu_grf
// Expected values are queued as stimulus is applied and drained once outputs settle.
module tb_alu_grf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic        cs_b = 1'b1;
  logic [3:0]  waddr = '0;
  logic [3:0]  wen = '0;
  logic [31:0] din = '0;
  logic [3:0]  raddr_0 = '0;
  logic [3:0]  raddr_1 = '0;
  logic [31:0] dout_0, dout_1;
  logic [31:0] alu_a = '0;
  logic [31:0] alu_b = '0;
  logic        cin = 1'b0;
  logic        vin = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] alu_dout;
  logic        cout, vout, mcp;

  alu_grf dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_cs_b(cs_b),
    .i_waddr(waddr), .i_wen(wen), .i_din(din),
    .i_raddr_0(raddr_0), .i_raddr_1(raddr_1),
    .o_dout_0(dout_0), .o_dout_1(dout_1),
    .i_alu_a(alu_a), .i_alu_b(alu_b), .i_cin(cin), .i_vin(vin),
    .i_opcode(opcode), .o_alu_dout(alu_dout), .o_cout(cout),
    .o_vout(vout), .o_mcp(mcp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [16];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: pick = dout_0;
      1: pick = dout_1;
      2: pick = alu_dout;
      3: pick = {31'b0, cout};
      4: pick = {31'b0, vout};
      default: pick = {31'b0, mcp};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = pick(e.sel);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d,
                    input logic en, input logic csb);
    @(negedge clk);
    waddr = a; wen = we; din = d; clk_en = en; cs_b = csb;
    @(posedge clk);
    if (en && !csb && !rst)
      for (int b = 0; b < 4; b++) if (we[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    #1;
    clk_en = 1'b0; cs_b = 1'b1; wen = '0;
  endtask

  task automatic rd(input string tag, input logic [3:0] r0, input logic [3:0] r1);
    raddr_0 = r0; raddr_1 = r1;
    push({tag, "_p0"}, 0, model[r0]);
    push({tag, "_p1"}, 1, model[r1]);
    #1;
    drain();
  endtask

  task automatic alu_t(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic vi,
                       input logic [31:0] res, input logic co, input logic vo,
                       input logic m);
    opcode = op; alu_a = a; alu_b = b; cin = ci; vin = vi;
    push({tag, "_res"}, 2, res);
    push({tag, "_cout"}, 3, {31'b0, co});
    push({tag, "_vout"}, 4, {31'b0, vo});
    push({tag, "_mcp"}, 5, {31'b0, m});
    #1;
    drain();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1 rst = 1'b1;
    #1 rd("rst_init", 4'd0, 4'd15);
    @(negedge clk) rst = 1'b0;

    wr(4'd3, 4'b1111, 32'h11223344, 1'b1, 1'b0);
    rd("r3_full", 4'd3, 4'd0);
    wr(4'd3, 4'b0100, 32'hAABBCCDD, 1'b1, 1'b0);
    push("r3_byte2_const", 0, 32'h11BB3344);
    rd("r3_byte2", 4'd3, 4'd3);
    wr(4'd3, 4'b1111, 32'h99999999, 1'b0, 1'b0);
    rd("r3_noclken", 4'd3, 4'd1);
    wr(4'd3, 4'b1111, 32'h99999999, 1'b1, 1'b1);
    rd("r3_csb_hi", 4'd3, 4'd2);
    wr(4'd3, 4'b0000, 32'h99999999, 1'b1, 1'b0);
    push("r3_wen0_const", 1, 32'h11BB3344);
    rd("r3_wen0", 4'd0, 4'd3);

    wr(4'd5, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b0);
    @(negedge clk);
    waddr = 4'd5; wen = 4'b1111; din = 32'h12345678; clk_en = 1'b1; cs_b = 1'b0;
    raddr_0 = 4'd5;
    push("wt_before", 0, 32'hCAFEF00D);
    #1 drain();
    @(posedge clk);
    model[5] = 32'h12345678;
    #1;
    clk_en = 1'b0; cs_b = 1'b1;
    push("wt_after", 0, 32'h12345678);
    drain();

    for (int i = 0; i < 16; i++)
      wr(4'(i), 4'b1111, $urandom() | 32'h1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) rd("fill", 4'(i), 4'(15 - i));

    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    for (int i = 0; i < 16; i++) rd("rst_mid", 4'(i), 4'(15 - i));
    alu_t("alu_in_rst", 6'h0A, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    wr(4'd7, 4'b1111, 32'h55555555, 1'b1, 1'b0);
    rd("wr_in_rst", 4'd7, 4'd3);
    @(negedge clk) rst = 1'b0;

    alu_t("add_wrap",  6'h0A, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu_t("add_ovf",   6'h0A, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    alu_t("sub_borrow",6'h0E, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    alu_t("sub_pos",   6'h0E, 32'h00000007, 32'h00000005, 1'b0, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0);
    alu_t("sub_ovf",   6'h0E, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    alu_t("adc",       6'h0C, 32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0);
    alu_t("sbc",       6'h10, 32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0);
    alu_t("asr",       6'h14, 32'h80000000, 32'h00000004, 1'b1, 1'b1, 32'hF8000000, 1'b0, 1'b1, 1'b0);
    alu_t("lsr",       6'h16, 32'h00000003, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0);
    alu_t("ror",       6'h1A, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
    alu_t("asl",       6'h18, 32'h40000001, 32'h00000002, 1'b0, 1'b0, 32'h00000004, 1'b1, 1'b0, 1'b0);
    alu_t("lsr_by0",   6'h16, 32'h00001234, 32'h00000020, 1'b1, 1'b0, 32'h00001234, 1'b1, 1'b0, 1'b0);
    alu_t("ror_by0",   6'h1A, 32'hABCD0000, 32'h00000000, 1'b0, 1'b1, 32'hABCD0000, 1'b0, 1'b1, 1'b0);
    alu_t("mul",       6'h12, 32'h00010000, 32'h00010001, 1'b1, 1'b0, 32'h00010000, 1'b1, 1'b0, 1'b1);
    alu_t("mul_small", 6'h12, 32'h00000007, 32'h00000006, 1'b0, 1'b1, 32'h0000002A, 1'b0, 1'b1, 1'b1);
    alu_t("lmovt",     6'h02, 32'hFFFFFFFF, 32'h00001234, 1'b0, 1'b1, 32'h12340000, 1'b0, 1'b1, 1'b0);
    alu_t("and",       6'h04, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
    alu_t("or",        6'h06, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 1'b0, 32'hFFF0FFF0, 1'b1, 1'b0, 1'b0);
    alu_t("xor",       6'h08, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b1, 32'hFF00FF00, 1'b0, 1'b1, 1'b0);
    alu_t("mov",       6'h00, 32'h11111111, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    alu_t("op_3f",     6'h3F, 32'h11111111, 32'h5A5A5A5A, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0);
    alu_t("op_13",     6'h13, 32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
